cpu_bus_arbiter: RTL and testbench

Parametrised CPU-bus arbiter that multiplexes the CPU and `N_CH` read-only DMA channels (APU sample DMA, OAM DMA, future expansion-audio DMA) onto the single PRG/WRAM/register bus. It sits between the CPU core and the address decoder.

- **Halting the CPU:** it stalls the CPU by gating its clock enable and inserts 2A03-style halt and alignment cycles.
- **Grants and return data:** it grants one bus read per CPU cycle to the highest-priority requester and returns registered read data to that channel.

---
 rtl/cpu_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// CPU-bus arbiter: shares the PRG/WRAM/register bus between the CPU and
// N_CH read-only DMA channels, stalling the CPU with halt/align cycles.
module cpu_bus_arbiter #(
    parameter int N_CH          = 2,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int GET_PUT_ALIGN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_en,
    output logic                     cpu_run,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic                     cpu_read,
    input  logic                     cpu_write,
    input  logic [N_CH-1:0]          dma_req,
    input  logic [N_CH*ADDR_W-1:0]   dma_addr,
    output logic [N_CH-1:0]          dma_grant,
    output logic [N_CH-1:0]          dma_rvalid,
    output logic [DATA_W-1:0]        dma_rdata,
    output logic                     dma_active,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    output logic                     bus_read,
    output logic                     bus_write,
    input  logic [DATA_W-1:0]        bus_rdata
);

    localparam logic [1:0] ST_CPU   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_ALIGN = 2'd2;
    localparam logic [1:0] ST_DMA   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              parity;      // parity of the current CPU cycle, 0 = get
    logic [N_CH-1:0]   grant;
    logic [N_CH-1:0]   grant_nxt;
    logic [N_CH-1:0]   winner;
    logic              align_ok;
    logic [ADDR_W-1:0] grant_addr;

    // Lowest-index request wins; the next cycle is a get when this one is a put.
    assign winner   = dma_req & (~dma_req + N_CH'(1));
    assign align_ok = (GET_PUT_ALIGN == 0) || (parity == 1'b1);

    // Next-state and slot-grant decision, applied only on cpu_en.
    always_comb begin
        state_nxt = state;
        grant_nxt = '0;
        case (state)
            ST_CPU: begin
                if ((|dma_req) && cpu_read && !cpu_write) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT:  state_nxt = align_ok ? ST_DMA : ST_ALIGN;
            ST_ALIGN: state_nxt = ST_DMA;
            ST_DMA: begin
                if (!(|dma_req)) begin
                    state_nxt = ST_CPU;
                end
            end
            default:  state_nxt = ST_CPU;
        endcase
        if ((state_nxt == ST_DMA) && align_ok) begin
            grant_nxt = winner;
        end
    end

    // State, get/put parity and the per-slot grant advance once per CPU cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_CPU;
            parity <= 1'b0;
            grant  <= '0;
        end else if (cpu_en) begin
            state  <= state_nxt;
            parity <= ~parity;
            grant  <= grant_nxt;
        end
    end

    // Capture read data and pulse rvalid at the strobe closing a granted slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            dma_rvalid <= '0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= cpu_en ? grant : '0;
            if (cpu_en && (|grant)) begin
                dma_rdata <= bus_rdata;
            end
        end
    end

    // Address of the channel owning the current slot (grant is one-hot).
    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                grant_addr = grant_addr | dma_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Bus mux and CPU clock-enable gating from registered state.
    always_comb begin
        cpu_run    = cpu_en && (state == ST_CPU);
        dma_active = (state != ST_CPU);
        dma_grant  = grant;
        bus_wdata  = cpu_wdata;
        bus_addr   = cpu_addr;
        bus_read   = cpu_read;
        bus_write  = 1'b0;
        case (state)
            ST_CPU:   bus_write = cpu_write;
            ST_HALT,
            ST_ALIGN: bus_read  = 1'b1;
            ST_DMA: begin
                bus_read = |grant;
                if (|grant) begin
                    bus_addr = grant_addr;
                end
            end
            default:  bus_write = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: aligned (2 ch), unaligned (2 ch) and
// aligned 4-channel instances driven in lockstep; one is observed at a time.
module tb_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;

    logic [3:0]  req_m;
    logic [15:0] addr_m [4];
    int          cnt [4];
    logic        drop_g;
    int          sel;

    int checks = 0;
    int errors = 0;

    // Memory contents seen by every instance.
    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Aligned, 2 channels
    logic       run_a, act_a, brd_a, bwr_a;
    logic [1:0] req_a, g_a, rv_a;
    logic [7:0] rdata_a, wd_a, brdata_a;
    logic [15:0] baddr_a;
    assign req_a    = (sel == 0) ? req_m[1:0] : 2'b00;
    assign brdata_a = mem(baddr_a);

    // Unaligned, 2 channels
    logic       run_u, act_u, brd_u, bwr_u;
    logic [1:0] req_u, g_u, rv_u;
    logic [7:0] rdata_u, wd_u, brdata_u;
    logic [15:0] baddr_u;
    assign req_u    = (sel == 1) ? req_m[1:0] : 2'b00;
    assign brdata_u = mem(baddr_u);

    // Aligned, 4 channels
    logic       run_4, act_4, brd_4, bwr_4;
    logic [3:0] req_4, g_4, rv_4;
    logic [7:0] rdata_4, wd_4, brdata_4;
    logic [15:0] baddr_4;
    assign req_4    = (sel == 2) ? req_m : 4'b0000;
    assign brdata_4 = mem(baddr_4);

    cpu_bus_arbiter #(.N_CH(2), .ADDR_W(16), .DATA_W(8), .GET_PUT_ALIGN(1)) u_a (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_run(run_a),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .dma_req(req_a), .dma_addr({addr_m[1], addr_m[0]}), .dma_grant(g_a),
        .dma_rvalid(rv_a), .dma_rdata(rdata_a), .dma_active(act_a),
        .bus_addr(baddr_a), .bus_wdata(wd_a), .bus_read(brd_a), .bus_write(bwr_a),
        .bus_rdata(brdata_a)
    );

    cpu_bus_arbiter #(.N_CH(2), .ADDR_W(16), .DATA_W(8), .GET_PUT_ALIGN(0)) u_u (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_run(run_u),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .dma_req(req_u), .dma_addr({addr_m[1], addr_m[0]}), .dma_grant(g_u),
        .dma_rvalid(rv_u), .dma_rdata(rdata_u), .dma_active(act_u),
        .bus_addr(baddr_u), .bus_wdata(wd_u), .bus_read(brd_u), .bus_write(bwr_u),
        .bus_rdata(brdata_u)
    );

    cpu_bus_arbiter #(.N_CH(4), .ADDR_W(16), .DATA_W(8), .GET_PUT_ALIGN(1)) u_4 (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_run(run_4),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .dma_req(req_4), .dma_addr({addr_m[3], addr_m[2], addr_m[1], addr_m[0]}), .dma_grant(g_4),
        .dma_rvalid(rv_4), .dma_rdata(rdata_4), .dma_active(act_4),
        .bus_addr(baddr_4), .bus_wdata(wd_4), .bus_read(brd_4), .bus_write(bwr_4),
        .bus_rdata(brdata_4)
    );

    // Observed instance selection.
    logic       obs_run, obs_act, obs_rd, obs_wr;
    logic [3:0] obs_g, obs_rv;
    logic [7:0] obs_rdata;
    logic [15:0] obs_addr;
    always_comb begin
        obs_run   = run_a;
        obs_act   = act_a;
        obs_rd    = brd_a;
        obs_wr    = bwr_a;
        obs_g     = {2'b00, g_a};
        obs_rv    = {2'b00, rv_a};
        obs_rdata = rdata_a;
        obs_addr  = baddr_a;
        if (sel == 1) begin
            obs_run   = run_u;
            obs_act   = act_u;
            obs_rd    = brd_u;
            obs_wr    = bwr_u;
            obs_g     = {2'b00, g_u};
            obs_rv    = {2'b00, rv_u};
            obs_rdata = rdata_u;
            obs_addr  = baddr_u;
        end else if (sel == 2) begin
            obs_run   = run_4;
            obs_act   = act_4;
            obs_rd    = brd_4;
            obs_wr    = bwr_4;
            obs_g     = g_4;
            obs_rv    = rv_4;
            obs_rdata = rdata_4;
            obs_addr  = baddr_4;
        end
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: checks the slot closed by this cpu_en, then the read
    // return; the requester model advances/drops on rvalid (or on grant).
    task automatic step(input logic e_run, input logic [3:0] e_g, input logic [15:0] e_a,
                        input logic e_rd, input logic e_wr, input logic [3:0] e_rv);
        @(negedge clk);
        cpu_en = 1'b1;
        #1;
        chk("cpu_run", 32'(obs_run), 32'(e_run));
        chk("dma_active", 32'(obs_act), 32'(!e_run));
        chk("dma_grant", 32'(obs_g), 32'(e_g));
        chk("bus_read", 32'(obs_rd), 32'(e_rd));
        chk("bus_write", 32'(obs_wr), 32'(e_wr));
        if (e_rd || e_wr) chk("bus_addr", 32'(obs_addr), 32'(e_a));
        @(negedge clk);
        cpu_en = 1'b0;
        #1;
        chk("dma_rvalid", 32'(obs_rv), 32'(e_rv));
        for (int i = 0; i < 4; i++) begin
            if (obs_rv[i]) begin
                chk("dma_rdata", 32'(obs_rdata), 32'(mem(addr_m[i])));
                addr_m[i] = addr_m[i] + 16'd1;
                cnt[i]    = cnt[i] - 1;
                if (cnt[i] <= 0) req_m[i] = 1'b0;
            end
            if (drop_g && obs_g[i] && (cnt[i] == 1)) req_m[i] = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; cpu_en = 1'b0; cpu_read = 1'b1; cpu_write = 1'b0;
        cpu_addr = 16'h8000; cpu_wdata = 8'h00; req_m = 4'h0; drop_g = 1'b0; sel = 0;
        for (int i = 0; i < 4; i++) begin addr_m[i] = 16'h0000; cnt[i] = 0; end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", 32'(obs_g), 32'h0);
        chk("rst_rvalid", 32'(obs_rv), 32'h0);
        chk("rst_rdata", 32'(obs_rdata), 32'h0);
        chk("rst_active", 32'(obs_act), 32'h0);
        chk("rst_run_lo", 32'(obs_run), 32'h0);
        cpu_en = 1'b1;
        #1;
        chk("rst_run_hi", 32'(obs_run), 32'h1);
        @(negedge clk);
        cpu_en = 1'b0; reset = 1'b0;

        // Single channel, aligned: CPU read on a put cycle -> HALT(get), ALIGN, 4 get slots
        step(1'b1, 4'h0, 16'h8000, 1'b1, 1'b0, 4'h0);
        req_m[1] = 1'b1; addr_m[1] = 16'h0200; cnt[1] = 4;
        step(1'b1, 4'h0, 16'h8000, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8000, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8000, 1'b1, 1'b0, 4'h0);
        for (int r = 0; r < 4; r++) begin
            step(1'b0, 4'h2, 16'h0200 + 16'(r), 1'b1, 1'b0, 4'h2);
            step(1'b0, 4'h0, 16'h8000, 1'b0, 1'b0, 4'h0);
        end
        step(1'b1, 4'h0, 16'h8000, 1'b1, 1'b0, 4'h0);

        // Halt deferred by three writes
        cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 16'h01FD; cpu_wdata = 8'h12;
        req_m[0] = 1'b1; addr_m[0] = 16'h0300; cnt[0] = 1;
        step(1'b1, 4'h0, 16'h01FD, 1'b0, 1'b1, 4'h0);
        chk("bus_wdata", 32'(wd_a), 32'h12);
        cpu_addr = 16'h01FC;
        step(1'b1, 4'h0, 16'h01FC, 1'b0, 1'b1, 4'h0);
        cpu_addr = 16'h01FB;
        step(1'b1, 4'h0, 16'h01FB, 1'b0, 1'b1, 4'h0);
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h8001;
        step(1'b1, 4'h0, 16'h8001, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8001, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h1, 16'h0300, 1'b1, 1'b0, 4'h1);
        step(1'b0, 4'h0, 16'h8001, 1'b0, 1'b0, 4'h0);
        step(1'b1, 4'h0, 16'h8001, 1'b1, 1'b0, 4'h0);

        // Preemption: ch0 takes the next get slot, ch1 resumes at 0x0211
        cpu_addr = 16'h8002; req_m[1] = 1'b1; addr_m[1] = 16'h0210; cnt[1] = 3;
        step(1'b1, 4'h0, 16'h8002, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8002, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8002, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h2, 16'h0210, 1'b1, 1'b0, 4'h2);
        req_m[0] = 1'b1; addr_m[0] = 16'hC000; cnt[0] = 1;
        step(1'b0, 4'h0, 16'h8002, 1'b0, 1'b0, 4'h0);
        step(1'b0, 4'h1, 16'hC000, 1'b1, 1'b0, 4'h1);
        step(1'b0, 4'h0, 16'h8002, 1'b0, 1'b0, 4'h0);
        step(1'b0, 4'h2, 16'h0211, 1'b1, 1'b0, 4'h2);
        step(1'b0, 4'h0, 16'h8002, 1'b0, 1'b0, 4'h0);
        step(1'b0, 4'h2, 16'h0212, 1'b1, 1'b0, 4'h2);
        step(1'b0, 4'h0, 16'h8002, 1'b0, 1'b0, 4'h0);
        step(1'b1, 4'h0, 16'h8002, 1'b1, 1'b0, 4'h0);

        // Reset landing on the strobe that would close a granted slot
        cpu_addr = 16'h8003; req_m[1] = 1'b1; addr_m[1] = 16'h0400; cnt[1] = 2;
        step(1'b1, 4'h0, 16'h8003, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8003, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8003, 1'b1, 1'b0, 4'h0);
        chk("pre_reset_grant", 32'(obs_g), 32'h2);
        reset = 1'b1; cpu_en = 1'b1; cpu_read = 1'b0; req_m = 4'h0;
        @(negedge clk);
        cpu_en = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(obs_g), 32'h0);
        chk("mid_rst_rvalid", 32'(obs_rv), 32'h0);
        chk("mid_rst_rdata", 32'(obs_rdata), 32'h0);
        chk("mid_rst_bus_read", 32'(obs_rd), 32'h0);
        chk("mid_rst_active", 32'(obs_act), 32'h0);
        chk("mid_rst_run_lo", 32'(obs_run), 32'h0);
        cpu_en = 1'b1;
        #1;
        chk("mid_rst_run_hi", 32'(obs_run), 32'h1);
        @(negedge clk);
        cpu_en = 1'b0; reset = 1'b0; cpu_read = 1'b1;
        for (int i = 0; i < 4; i++) cnt[i] = 0;

        // Unaligned: 1 HALT + 1 DMA cycle, then a back-to-back 2-read burst
        sel = 1; drop_g = 1'b1; cpu_addr = 16'h8004;
        req_m[0] = 1'b1; addr_m[0] = 16'h0500; cnt[0] = 1;
        step(1'b1, 4'h0, 16'h8004, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8004, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h1, 16'h0500, 1'b1, 1'b0, 4'h1);
        step(1'b1, 4'h0, 16'h8004, 1'b1, 1'b0, 4'h0);
        req_m[1] = 1'b1; addr_m[1] = 16'h0600; cnt[1] = 2;
        step(1'b1, 4'h0, 16'h8004, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8004, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h2, 16'h0600, 1'b1, 1'b0, 4'h2);
        step(1'b0, 4'h2, 16'h0601, 1'b1, 1'b0, 4'h2);
        step(1'b1, 4'h0, 16'h8004, 1'b1, 1'b0, 4'h0);

        // Four channels requesting together: grants 0,1,2,3 on get slots
        sel = 2; drop_g = 1'b0; cpu_addr = 16'h8005; req_m = 4'hF;
        for (int i = 0; i < 4; i++) begin addr_m[i] = 16'h0700 + 16'(i); cnt[i] = 1; end
        step(1'b1, 4'h0, 16'h8005, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8005, 1'b1, 1'b0, 4'h0);
        step(1'b0, 4'h0, 16'h8005, 1'b1, 1'b0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 4'(1 << c), 16'h0700 + 16'(c), 1'b1, 1'b0, 4'(1 << c));
            step(1'b0, 4'h0, 16'h8005, 1'b0, 1'b0, 4'h0);
        end
        step(1'b1, 4'h0, 16'h8005, 1'b1, 1'b0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
